// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, access owner and
// the request bundle that is forwarded to the single-port memory.
package riscv_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // Full-word byte mask used for every instruction fetch.
    localparam logic [3:0] BE_WORD = 4'hF;

    // One memory access as presented to the macro; addr is kept at the
    // widest supported width and trimmed to ADDR_W at the port.
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the CPU fetch port and
// its load/store port. Data wins over fetch unless fetch has already waited
// through MAX_DATA_RUN consecutive data grants. One access in flight at most.
//
// Handshake: a requester raises *_req_i with a stable payload and holds both
// until the cycle it sees *_gnt_o (a one-cycle pulse, issued combinationally
// while the arbiter is idle). Exactly one *_rvalid_o pulse follows each grant,
// MEM_LATENCY cycles later; *_rdata_o is zero whenever its rvalid is low.
// Dropping a request before its grant withdraws it. Reset abandons any access
// in flight without a response.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    // Reject parameter values the 3-bit latency and 4-bit run counters cannot hold.
    if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
        $error("riscv_mem_arbiter: MEM_LATENCY must be in 1..7");
    end
    if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 15) begin : g_bad_run
        $error("riscv_mem_arbiter: MAX_DATA_RUN must be in 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 32) begin : g_bad_addr_w
        $error("riscv_mem_arbiter: ADDR_W must be in 1..32");
    end

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] RUN_MAX  = 4'(MAX_DATA_RUN);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    logic [2:0] lat_q, lat_d;
    logic [3:0] run_q, run_d;

    mem_req_t   req;
    logic       fetch_wins;
    logic       data_wins;

    // Arbitration, access sequencing, run-counter update and response routing.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lat_d      = lat_q;
        run_d      = run_q;
        i_gnt_o    = 1'b0;
        d_gnt_o    = 1'b0;
        i_rvalid_o = 1'b0;
        d_rvalid_o = 1'b0;
        i_rdata_o  = 32'h0;
        d_rdata_o  = 32'h0;
        mem_req_o  = 1'b0;
        req        = '0;

        // Fetch takes the slot when data is absent or has used up its run.
        fetch_wins = i_req_i && (!d_req_i || (run_q == RUN_MAX));
        data_wins  = d_req_i && !fetch_wins;

        case (state_q)
            IDLE: begin
                if (data_wins) begin
                    d_gnt_o    = 1'b1;
                    mem_req_o  = 1'b1;
                    req.we     = d_we_i;
                    req.be     = d_be_i;
                    req.addr   = 32'(d_addr_i);
                    req.wdata  = d_wdata_i;
                    owner_d    = OWNER_DATA;
                    lat_d      = LAT_LOAD;
                    state_d    = ACCESS;
                end else if (fetch_wins) begin
                    i_gnt_o    = 1'b1;
                    mem_req_o  = 1'b1;
                    req.we     = 1'b0;
                    req.be     = BE_WORD;
                    req.addr   = 32'(i_addr_i);
                    owner_d    = OWNER_FETCH;
                    lat_d      = LAT_LOAD;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_q != 3'd0) begin
                    lat_d = lat_q - 3'd1;
                end else begin
                    state_d = IDLE;
                    if (owner_q == OWNER_DATA) begin
                        d_rvalid_o = 1'b1;
                        d_rdata_o  = mem_rdata_i;
                    end else begin
                        i_rvalid_o = 1'b1;
                        i_rdata_o  = mem_rdata_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The run only counts data grants taken while fetch is actually waiting.
        if (!i_req_i || i_gnt_o) begin
            run_d = 4'd0;
        end else if (d_gnt_o && (run_q != RUN_MAX)) begin
            run_d = run_q + 4'd1;
        end

        // Reset overrides anything that would otherwise happen this cycle.
        if (reset) begin
            i_gnt_o    = 1'b0;
            d_gnt_o    = 1'b0;
            i_rvalid_o = 1'b0;
            d_rvalid_o = 1'b0;
            i_rdata_o  = 32'h0;
            d_rdata_o  = 32'h0;
            mem_req_o  = 1'b0;
            req        = '0;
        end
    end

    // State, owner and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWNER_FETCH;
            lat_q   <= 3'd0;
            run_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            run_q   <= run_d;
        end
    end

    assign mem_we_o    = req.we;
    assign mem_be_o    = req.be;
    assign mem_addr_o  = req.addr[ADDR_W-1:0];
    assign mem_wdata_o = req.wdata;
    assign busy_o      = (state_q == ACCESS);
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: two instances (MEM_LATENCY 1 and 3) behind a
// byte-enabled word memory, a timestamp-based reference model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_riscv_mem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        i_req    [2];
    logic [31:0] i_addr   [2];
    logic        i_gnt    [2];
    logic        i_rvalid [2];
    logic [31:0] i_rdata  [2];
    logic        d_req    [2];
    logic        d_we     [2];
    logic [3:0]  d_be     [2];
    logic [31:0] d_addr   [2];
    logic [31:0] d_wdata  [2];
    logic        d_gnt    [2];
    logic        d_rvalid [2];
    logic [31:0] d_rdata  [2];
    logic        mem_req  [2];
    logic        mem_we   [2];
    logic [3:0]  mem_be   [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];
    logic        busy     [2];
    logic        owner    [2];

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- DUTs ----------------
    for (genvar k = 0; k < 2; k++) begin : g_dut
        riscv_mem_arbiter #(
            .ADDR_W      (32),
            .MEM_LATENCY ((k == 0) ? 1 : 3),
            .MAX_DATA_RUN(4)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .i_req_i    (i_req[k]),
            .i_addr_i   (i_addr[k]),
            .i_gnt_o    (i_gnt[k]),
            .i_rvalid_o (i_rvalid[k]),
            .i_rdata_o  (i_rdata[k]),
            .d_req_i    (d_req[k]),
            .d_we_i     (d_we[k]),
            .d_be_i     (d_be[k]),
            .d_addr_i   (d_addr[k]),
            .d_wdata_i  (d_wdata[k]),
            .d_gnt_o    (d_gnt[k]),
            .d_rvalid_o (d_rvalid[k]),
            .d_rdata_o  (d_rdata[k]),
            .mem_req_o  (mem_req[k]),
            .mem_we_o   (mem_we[k]),
            .mem_be_o   (mem_be[k]),
            .mem_addr_o (mem_addr[k]),
            .mem_wdata_o(mem_wdata[k]),
            .mem_rdata_i(mem_rdata[k]),
            .busy_o     (busy[k]),
            .owner_o    (owner[k])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // ---------------- memory (one per DUT) ----------------
    logic [31:0] mem_arr [2][256];
    logic [7:0]  rd_idx  [2];

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int j = 0; j < 256; j++) mem_arr[k][j] <= 32'h0;
                mem_arr[k][8'h04] <= 32'h00A00093;   // 0x010
                mem_arr[k][8'h08] <= 32'h00000013;   // 0x020
                mem_arr[k][8'h40] <= 32'h12345678;   // 0x100
                rd_idx[k] <= 8'h0;
            end else if (mem_req[k]) begin
                automatic logic [31:0] w = mem_arr[k][mem_addr[k][9:2]];
                rd_idx[k] <= mem_addr[k][9:2];
                if (mem_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[k][b]) w[8*b +: 8] = mem_wdata[k][8*b +: 8];
                    mem_arr[k][mem_addr[k][9:2]] <= w;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) mem_rdata[k] = mem_arr[k][rd_idx[k]];
    end

    // ---------------- scoreboard helper ----------------
    function automatic void chk(input int k, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [dut%0d] %s: got 0x%0h, expected 0x%0h at %0t", k, name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    // The model tracks, per DUT, the cycle number at which the outstanding
    // access responds (due), who owns it, and how many data grants fetch has
    // watched go by.
    int          cyc = 0;
    int          due     [2] = '{-1, -1};
    logic        own_m   [2] = '{1'b0, 1'b0};
    logic        st_m    [2] = '{1'b0, 1'b0};
    int          run_m   [2] = '{0, 0};
    logic [31:0] word_m  [2] = '{32'h0, 32'h0};

    always @(negedge clock) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            logic        e_busy, resp, e_ir, e_dr, e_we;
            logic [3:0]  e_be;
            logic [31:0] e_addr, e_wd;
            int          win;   // 0 none, 1 fetch, 2 data
            e_busy = (cyc <= due[k]);
            resp   = !reset && e_busy && (cyc == due[k]);
            e_ir   = resp && !own_m[k];
            e_dr   = resp && own_m[k];
            win    = 0;
            if (!reset && !e_busy) begin
                if (d_req[k] && !(i_req[k] && run_m[k] == 4)) win = 2;
                else if (i_req[k]) win = 1;
            end
            e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
            if (win == 2) begin
                e_we = d_we[k]; e_be = d_be[k]; e_addr = d_addr[k]; e_wd = d_wdata[k];
            end else if (win == 1) begin
                e_be = 4'hF; e_addr = i_addr[k];
            end

            chk(k, "i_gnt",     i_gnt[k],    win == 1);
            chk(k, "d_gnt",     d_gnt[k],    win == 2);
            chk(k, "mem_req",   mem_req[k],  win != 0);
            chk(k, "mem_we",    mem_we[k],   e_we);
            chk(k, "mem_be",    mem_be[k],   e_be);
            chk(k, "mem_addr",  mem_addr[k], e_addr);
            if (win != 1) chk(k, "mem_wdata", mem_wdata[k], e_wd);
            chk(k, "i_rvalid",  i_rvalid[k], e_ir);
            chk(k, "d_rvalid",  d_rvalid[k], e_dr);
            chk(k, "i_rdata",   i_rdata[k],  e_ir ? word_m[k] : 32'h0);
            if (!(e_dr && st_m[k])) chk(k, "d_rdata", d_rdata[k], e_dr ? word_m[k] : 32'h0);
            chk(k, "busy",      busy[k],     e_busy);
            chk(k, "owner",     owner[k],    own_m[k]);

            if (reset) begin
                due[k]   = cyc;
                own_m[k] = 1'b0;
                run_m[k] = 0;
            end else begin
                if (win != 0) begin
                    due[k]    = cyc + lat_of(k);
                    own_m[k]  = (win == 2);
                    st_m[k]   = (win == 2) && d_we[k];
                    word_m[k] = mem_arr[k][e_addr[9:2]];
                end
                if (!i_req[k] || win == 1) run_m[k] = 0;
                else if (win == 2 && run_m[k] < 4) run_m[k] = run_m[k] + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_fetch(input int k, input logic [31:0] addr,
                            output int gw, output int lat, output logic [31:0] rd);
        @(posedge clock); #1;
        i_req[k] = 1'b1; i_addr[k] = addr; gw = 0;
        @(negedge clock);
        while (!i_gnt[k] && gw < 50) begin gw++; @(negedge clock); end
        @(posedge clock); #1;
        i_req[k] = 1'b0;
        lat = 0;
        do begin @(negedge clock); lat++; end while (!i_rvalid[k] && lat < 20);
        rd = i_rdata[k];
    endtask

    task automatic do_data(input int k, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int gw, output int lat, output logic [31:0] rd);
        @(posedge clock); #1;
        d_req[k] = 1'b1; d_we[k] = we; d_be[k] = be; d_addr[k] = addr; d_wdata[k] = wdata;
        gw = 0;
        @(negedge clock);
        while (!d_gnt[k] && gw < 50) begin gw++; @(negedge clock); end
        @(posedge clock); #1;
        d_req[k] = 1'b0;
        lat = 0;
        do begin @(negedge clock); lat++; end while (!d_rvalid[k] && lat < 20);
        rd = d_rdata[k];
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int          gw, lat, dg_before, dg_after;
        logic        fetch_seen;
        logic [31:0] rd;

        for (int k = 0; k < 2; k++) begin
            i_req[k] = 1'b0; i_addr[k] = 32'h0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_be[k] = 4'h0;
            d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk(0, "rst_busy", busy[0], 1'b0);
        chk(1, "rst_owner", owner[1], 1'b0);

        // Single fetch, MEM_LATENCY=1
        @(posedge clock); #1;
        i_req[0] = 1'b1; i_addr[0] = 32'h10;
        @(negedge clock);
        chk(0, "t1_gnt_c0", i_gnt[0], 1'b1);
        chk(0, "t1_busy_c0", busy[0], 1'b0);
        @(posedge clock); #1;
        i_req[0] = 1'b0;
        @(negedge clock);
        chk(0, "t1_rvalid_c1", i_rvalid[0], 1'b1);
        chk(0, "t1_rdata_c1", i_rdata[0], 32'h00A00093);
        chk(0, "t1_busy_c1", busy[0], 1'b1);
        @(negedge clock);
        chk(0, "t1_busy_c2", busy[0], 1'b0);

        // Simultaneous requests: data first, fetch two cycles later
        @(posedge clock); #1;
        i_req[0] = 1'b1; i_addr[0] = 32'h20;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_be[0] = 4'hF; d_addr[0] = 32'h100;
        @(negedge clock);
        chk(0, "t2_dgnt_c0", d_gnt[0], 1'b1);
        chk(0, "t2_ignt_c0", i_gnt[0], 1'b0);
        @(posedge clock); #1;
        d_req[0] = 1'b0;
        @(negedge clock);
        chk(0, "t2_drvalid_c1", d_rvalid[0], 1'b1);
        chk(0, "t2_drdata_c1", d_rdata[0], 32'h12345678);
        @(negedge clock);
        chk(0, "t2_ignt_c2", i_gnt[0], 1'b1);
        @(posedge clock); #1;
        i_req[0] = 1'b0;
        @(negedge clock);
        chk(0, "t2_irvalid_c3", i_rvalid[0], 1'b1);
        chk(0, "t2_irdata_c3", i_rdata[0], 32'h00000013);

        // Starvation guard: 4 data grants, then fetch, then data resumes
        @(posedge clock); #1;
        i_req[0] = 1'b1; i_addr[0] = 32'h20;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_be[0] = 4'hF; d_addr[0] = 32'h100;
        dg_before = 0; dg_after = 0; fetch_seen = 1'b0;
        for (int c = 0; c < 60 && dg_after == 0; c++) begin
            @(negedge clock);
            if (i_gnt[0]) fetch_seen = 1'b1;
            if (d_gnt[0]) begin
                if (fetch_seen) dg_after++;
                else dg_before++;
            end
            @(posedge clock); #1;
            if (fetch_seen) i_req[0] = 1'b0;
        end
        d_req[0] = 1'b0;
        chk(0, "t3_data_run", dg_before, 4);
        chk(0, "t3_fetch_granted", fetch_seen, 1'b1);
        chk(0, "t3_data_resumed", dg_after, 1);
        repeat (3) @(negedge clock);

        // Store then load, MEM_LATENCY=3
        do_data(1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF, gw, lat, rd);
        chk(1, "t4_sw_gnt_wait", gw, 0);
        chk(1, "t4_sw_latency", lat, 3);
        do_data(1, 1'b0, 4'hF, 32'h200, 32'h0, gw, lat, rd);
        chk(1, "t4_lw_latency", lat, 3);
        chk(1, "t4_lw_data", rd, 32'hDEADBEEF);
        do_data(1, 1'b1, 4'b0010, 32'h200, 32'h0000AB00, gw, lat, rd);
        chk(1, "t4_sb_latency", lat, 3);
        do_data(1, 1'b0, 4'hF, 32'h200, 32'h0, gw, lat, rd);
        chk(1, "t4_lw2_data", rd, 32'hDEADABEF);

        // Reset one cycle after a fetch grant, MEM_LATENCY=3
        @(posedge clock); #1;
        i_req[1] = 1'b1; i_addr[1] = 32'h10;
        @(negedge clock);
        chk(1, "t5_gnt_c0", i_gnt[1], 1'b1);
        @(posedge clock); #1;
        i_req[1] = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk(1, "t5_rvalid_rst", i_rvalid[1], 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk(1, "t5_busy_after", busy[1], 1'b0);
        chk(1, "t5_rvalid_after", i_rvalid[1], 1'b0);
        chk(1, "t5_memreq_after", mem_req[1], 1'b0);
        chk(1, "t5_owner_after", owner[1], 1'b0);
        @(negedge clock);
        chk(1, "t5_rvalid_c3", i_rvalid[1], 1'b0);
        do_fetch(1, 32'h10, gw, lat, rd);
        chk(1, "t5_new_gnt_wait", gw, 0);
        chk(1, "t5_new_latency", lat, 3);
        chk(1, "t5_new_rdata", rd, 32'h00A00093);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
